// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the grid calculator keystroke
//               interpreter: key codes, operator and state encodings, and
//               key-classification helpers.
// Config      : CALC_MULT_EN - when undefined, KEY_MULT is not an operator key
//               and is ignored by the interpreter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  // Key codes delivered by the grid cursor (0x00-0x0F are digits)
  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_MULT = 5'h11;
  localparam logic [4:0] KEY_AND  = 5'h12;
  localparam logic [4:0] KEY_EXE  = 5'h13;
  localparam logic [4:0] KEY_SUB  = 5'h14;
  localparam logic [4:0] KEY_OR   = 5'h15;
  localparam logic [4:0] KEY_CE   = 5'h16;
  localparam logic [4:0] KEY_CLR  = 5'h17;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MULT = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } state_t;

  // True for keys that latch an operator. MULT only counts when the
  // multiplier exists; otherwise it falls through as an ignored code.
  function automatic logic f_is_op_key(input logic [4:0] k);
    case (k)
      KEY_ADD, KEY_SUB, KEY_AND, KEY_OR: return 1'b1;
`ifdef CALC_MULT_EN
      KEY_MULT:                          return 1'b1;
`endif
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic op_t f_key_op(input logic [4:0] k);
    case (k)
      KEY_SUB:  return OP_SUB;
      KEY_MULT: return OP_MULT;
      KEY_AND:  return OP_AND;
      KEY_OR:   return OP_OR;
      default:  return OP_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_alu.sv
// ============================================================================
// Module      : calc_alu
// Description : Combinational unsigned ALU, results truncated to W bits.
//               ADD: ovf = carry out. SUB: ovf = borrow, result wraps.
//               MULT: ovf = upper half of product nonzero. AND/OR: ovf = 0.
// Ports       : i_a, i_b  - operands (W bits)
//               i_op      - operator (op_t)
//               o_result  - W-bit result
//               o_ovf     - overflow / borrow flag
// Config      : CALC_MULT_EN - includes the multiplier path when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_alu
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  op_t          i_op,
  output logic [W-1:0] o_result,
  output logic         o_ovf
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the extended difference is set exactly when i_a < i_b
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

`ifdef CALC_MULT_EN
  logic [2*W-1:0] w_prod;
  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
`endif

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[W-1:0];
        o_ovf    = w_sum[W];
      end
      OP_SUB: begin
        o_result = w_diff[W-1:0];
        o_ovf    = w_diff[W];
      end
`ifdef CALC_MULT_EN
      OP_MULT: begin
        o_result = w_prod[W-1:0];
        o_ovf    = |w_prod[2*W-1:W];
      end
`endif
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      default: begin
        o_result = '0;
        o_ovf    = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/calc_entry_fsm.sv
// ============================================================================
// Module      : calc_entry_fsm
// Description : Keystroke interpreter for the grid calculator. Accumulates
//               operand digits (hex or decimal), latches operators, chains
//               and executes arithmetic, and selects the displayed value.
// Ports       : clk, rst (async, active-high)
//               key_press/key_val - confirmed key and its 5-bit code
//               dec_mode          - 1 = decimal entry, 0 = hex entry
//               restriction       - dec_mode registered, back to the cursor
//               disp_val/disp_sel - displayed value and its source (A/B/R)
//               op_cur, ovf, state - latched operator, overflow, FSM state
// Config      : CALC_MULT_EN - enables the MULT key (0x11) and multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_press,
  input  logic [4:0]            key_val,
  input  logic                  dec_mode,
  output logic                  restriction,
  output logic [4*N_DIGITS-1:0] disp_val,
  output logic [1:0]            disp_sel,
  output logic [2:0]            op_cur,
  output logic                  ovf,
  output logic [1:0]            state
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] c_max_cnt = CW'(N_DIGITS);

  state_t          r_state, w_state_nxt;
  op_t             r_op,    w_op_nxt;
  logic [W-1:0]    r_a,     w_a_nxt;
  logic [W-1:0]    r_b,     w_b_nxt;
  logic [W-1:0]    r_r,     w_r_nxt;
  logic [CW-1:0]   r_cnt_a, w_cnt_a_nxt;
  logic [CW-1:0]   r_cnt_b, w_cnt_b_nxt;
  logic            r_ovf,   w_ovf_nxt;
  logic            r_restr;

  logic            w_dig_ok;
  logic            w_is_op;
  op_t             w_key_op;
  logic [W-1:0]    w_alu_res;
  logic            w_alu_ovf;

  // Shift in one digit in the current radix; the digit limit keeps the
  // decimal value below 10^N_DIGITS, so truncation never occurs there.
  function automatic logic [W-1:0] f_acc(input logic [W-1:0] acc,
                                         input logic [3:0]   d,
                                         input logic         dec);
    if (dec) return (acc * W'(10)) + W'(d);
    else     return (acc << 4) | W'(d);
  endfunction

  assign w_dig_ok = (key_val[4] == 1'b0) &&
                    (!dec_mode || (key_val[3:0] <= 4'd9));
  assign w_is_op  = f_is_op_key(key_val);
  assign w_key_op = f_key_op(key_val);

  calc_alu #(.W(W)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res),
    .o_ovf    (w_alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_A;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_ovf   <= 1'b0;
      r_restr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_r     <= w_r_nxt;
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
      r_ovf   <= w_ovf_nxt;
      r_restr <= dec_mode;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_r_nxt     = r_r;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_ovf_nxt   = r_ovf;

    if (key_press) begin
      // CE on a displayed result has nothing to edit, so it acts as CLR
      if ((key_val == KEY_CLR) || ((key_val == KEY_CE) && (r_state == S_RES))) begin
        w_state_nxt = S_A;
        w_op_nxt    = OP_ADD;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_r_nxt     = '0;
        w_cnt_a_nxt = '0;
        w_cnt_b_nxt = '0;
        w_ovf_nxt   = 1'b0;
      end else begin
        case (r_state)
          S_A: begin
            if (w_dig_ok) begin
              if (r_cnt_a < c_max_cnt) begin
                w_a_nxt     = f_acc(r_a, key_val[3:0], dec_mode);
                w_cnt_a_nxt = r_cnt_a + CW'(1);
              end
            end else if (w_is_op) begin
              w_op_nxt    = w_key_op;
              w_b_nxt     = '0;
              w_cnt_b_nxt = '0;
              w_state_nxt = S_B;
            end else if (key_val == KEY_CE) begin
              w_a_nxt     = '0;
              w_cnt_a_nxt = '0;
            end
          end
          S_B: begin
            if (w_dig_ok) begin
              if (r_cnt_b < c_max_cnt) begin
                w_b_nxt     = f_acc(r_b, key_val[3:0], dec_mode);
                w_cnt_b_nxt = r_cnt_b + CW'(1);
              end
            end else if (w_is_op) begin
              // With no B digits yet the key only changes its mind about op
              if (r_cnt_b != '0) begin
                w_a_nxt     = w_alu_res;
                w_ovf_nxt   = w_alu_ovf;
                w_b_nxt     = '0;
                w_cnt_b_nxt = '0;
              end
              w_op_nxt = w_key_op;
            end else if (key_val == KEY_EXE) begin
              w_r_nxt     = w_alu_res;
              w_ovf_nxt   = w_alu_ovf;
              w_state_nxt = S_RES;
            end else if (key_val == KEY_CE) begin
              w_b_nxt     = '0;
              w_cnt_b_nxt = '0;
            end
          end
          S_RES: begin
            if (w_dig_ok) begin
              w_state_nxt = S_A;
              w_op_nxt    = OP_ADD;
              w_a_nxt     = W'(key_val[3:0]);
              w_cnt_a_nxt = CW'(1);
              w_b_nxt     = '0;
              w_cnt_b_nxt = '0;
              w_r_nxt     = '0;
              w_ovf_nxt   = 1'b0;
            end else if (w_is_op) begin
              w_a_nxt     = r_r;
              w_op_nxt    = w_key_op;
              w_b_nxt     = '0;
              w_cnt_b_nxt = '0;
              w_state_nxt = S_B;
            end
          end
          default: w_state_nxt = S_A;
        endcase
      end
    end
  end

  always_comb begin
    disp_val = r_a;
    disp_sel = 2'd0;
    case (r_state)
      S_B: begin
        if (r_cnt_b != '0) begin
          disp_val = r_b;
          disp_sel = 2'd1;
        end
      end
      S_RES: begin
        disp_val = r_r;
        disp_sel = 2'd2;
      end
      default: begin
        disp_val = r_a;
        disp_sel = 2'd0;
      end
    endcase
  end

  assign restriction = r_restr;
  assign op_cur      = r_op;
  assign ovf         = r_ovf;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_fsm.sv
// ============================================================================
// Module      : tb_calc_entry_fsm
// Description : Self-checking bench for calc_entry_fsm: directed vector
//               table, hand-written reset/latency sequences, and random keys
//               against a behavioural reference model.
// Config      : CALC_MULT_EN - bench expectations follow the same macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_entry_fsm;
  import calc_pkg::*;

  localparam int     N_DIGITS = 4;
  localparam int     W        = 4 * N_DIGITS;
  localparam longint MOD      = 64'd1 << W;
`ifdef CALC_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_press = 1'b0;
  logic [4:0]   key_val = 5'h00;
  logic         dec_mode = 1'b0;
  logic         restriction;
  logic [W-1:0] disp_val;
  logic [1:0]   disp_sel;
  logic [2:0]   op_cur;
  logic         ovf;
  logic [1:0]   state;

  calc_entry_fsm #(.N_DIGITS(N_DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_press   (key_press),
    .key_val     (key_val),
    .dec_mode    (dec_mode),
    .restriction (restriction),
    .disp_val    (disp_val),
    .disp_sel    (disp_sel),
    .op_cur      (op_cur),
    .ovf         (ovf),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_a, m_b, m_r;
  int     m_ca, m_cb, m_st, m_op;
  bit     m_ovf, m_restr;

  task automatic m_reset();
    m_a = 0; m_b = 0; m_r = 0; m_ca = 0; m_cb = 0;
    m_st = 0; m_op = int'(OP_ADD); m_ovf = 0; m_restr = 0;
  endtask

  task automatic m_calc(input int op, input longint a, input longint b,
                        output longint res, output bit o);
    longint t;
    res = 0; o = 0;
    if (op == int'(OP_ADD))      begin t = a + b; res = t % MOD; o = (t >= MOD); end
    else if (op == int'(OP_SUB)) begin res = (a - b + MOD) % MOD; o = (a < b); end
    else if (op == int'(OP_MULT)) begin t = a * b; res = t % MOD; o = (t >= MOD); end
    else if (op == int'(OP_AND)) res = a & b;
    else if (op == int'(OP_OR))  res = a | b;
  endtask

  function automatic int m_opcode(input int k);
    case (k)
      'h10: return int'(OP_ADD);
      'h11: return MULT_EN ? int'(OP_MULT) : -1;
      'h12: return int'(OP_AND);
      'h14: return int'(OP_SUB);
      'h15: return int'(OP_OR);
      default: return -1;
    endcase
  endfunction

  task automatic m_step(input bit p, input int k, input bit d);
    bit     dok;
    int     opk;
    longint res;
    bit     o;
    m_restr = d;
    if (!p) return;
    dok = (k < 16) && (!d || k <= 9);
    opk = m_opcode(k);
    if (k == 'h17 || (k == 'h16 && m_st == 2)) begin
      m_reset(); m_restr = d;
    end else if (m_st == 0) begin
      if (dok) begin
        if (m_ca < N_DIGITS) begin m_a = (m_a * (d ? 10 : 16) + k) % MOD; m_ca++; end
      end else if (opk >= 0) begin m_op = opk; m_b = 0; m_cb = 0; m_st = 1; end
      else if (k == 'h16) begin m_a = 0; m_ca = 0; end
    end else if (m_st == 1) begin
      if (dok) begin
        if (m_cb < N_DIGITS) begin m_b = (m_b * (d ? 10 : 16) + k) % MOD; m_cb++; end
      end else if (opk >= 0) begin
        if (m_cb > 0) begin m_calc(m_op, m_a, m_b, res, o); m_a = res; m_ovf = o; m_b = 0; m_cb = 0; end
        m_op = opk;
      end else if (k == 'h13) begin
        m_calc(m_op, m_a, m_b, res, o); m_r = res; m_ovf = o; m_st = 2;
      end else if (k == 'h16) begin m_b = 0; m_cb = 0; end
    end else begin
      if (dok) begin
        m_reset(); m_restr = d; m_a = k; m_ca = 1;
      end else if (opk >= 0) begin
        m_a = m_r; m_op = opk; m_b = 0; m_cb = 0; m_st = 1;
      end
    end
  endtask

  task automatic m_compare(input string tag);
    longint ev;
    int     es;
    if (m_st == 2)      begin ev = m_r; es = 2; end
    else if (m_st == 1 && m_cb > 0) begin ev = m_b; es = 1; end
    else                begin ev = m_a; es = 0; end
    chk({tag, "_val"},   32'(disp_val), 32'(ev));
    chk({tag, "_sel"},   32'(disp_sel), 32'(es));
    chk({tag, "_state"}, 32'(state),    32'(m_st));
    chk({tag, "_op"},    32'(op_cur),   32'(m_op));
    chk({tag, "_ovf"},   32'(ovf),      32'(m_ovf));
    chk({tag, "_restr"}, 32'(restriction), 32'(m_restr));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]   key;
    logic         dec;
    logic [W-1:0] val;
    logic [1:0]   sel;
    logic [1:0]   st;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic [4:0] k, input logic d, input logic [W-1:0] val,
                   input logic [1:0] sel, input logic [1:0] st, input logic o);
    vec_t e;
    e.key = k; e.dec = d; e.val = val; e.sel = sel; e.st = st; e.ovf = o;
    vecs.push_back(e);
  endtask

  // Apply one cycle of inputs, let the edge happen, then sample 1 time unit later
  task automatic step(input bit p, input logic [4:0] k, input bit d);
    key_press = p; key_val = k; dec_mode = d;
    @(posedge clk);
    m_step(p, int'(k), d);
    #1;
    key_press = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_press = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    // hex basics
    v(5'h1, 0, 16'h0001, 0, 0, 0); v(5'h2, 0, 16'h0012, 0, 0, 0);
    v(KEY_ADD, 0, 16'h0012, 0, 1, 0); v(5'h3, 0, 16'h0003, 1, 1, 0);
    v(5'h4, 0, 16'h0034, 1, 1, 0); v(KEY_EXE, 0, 16'h0046, 2, 2, 0);
    v(KEY_CLR, 0, 16'h0000, 0, 0, 0);
    // digit limit and ADD overflow, then operator on a result
    v(5'hF, 0, 16'h000F, 0, 0, 0); v(5'hF, 0, 16'h00FF, 0, 0, 0);
    v(5'hF, 0, 16'h0FFF, 0, 0, 0); v(5'hF, 0, 16'hFFFF, 0, 0, 0);
    v(5'hF, 0, 16'hFFFF, 0, 0, 0); v(KEY_ADD, 0, 16'hFFFF, 0, 1, 0);
    v(5'h1, 0, 16'h0001, 1, 1, 0); v(KEY_EXE, 0, 16'h0000, 2, 2, 1);
    v(KEY_SUB, 0, 16'h0000, 0, 1, 1); v(KEY_CLR, 0, 16'h0000, 0, 0, 0);
    // chaining and CE in S_B
    v(5'h5, 0, 16'h0005, 0, 0, 0); v(KEY_ADD, 0, 16'h0005, 0, 1, 0);
    v(5'h3, 0, 16'h0003, 1, 1, 0); v(KEY_SUB, 0, 16'h0008, 0, 1, 0);
    v(5'h7, 0, 16'h0007, 1, 1, 0); v(KEY_CE, 0, 16'h0008, 0, 1, 0);
    v(5'h2, 0, 16'h0002, 1, 1, 0); v(KEY_EXE, 0, 16'h0006, 2, 2, 0);
    v(KEY_CLR, 0, 16'h0000, 0, 0, 0);
    // SUB borrow, digit in S_RES, CE in S_A
    v(5'h2, 0, 16'h0002, 0, 0, 0); v(KEY_SUB, 0, 16'h0002, 0, 1, 0);
    v(5'h5, 0, 16'h0005, 1, 1, 0); v(KEY_EXE, 0, 16'hFFFD, 2, 2, 1);
    v(5'h7, 0, 16'h0007, 0, 0, 0); v(KEY_CE, 0, 16'h0000, 0, 0, 0);
    // AND then OR chained, CE in S_RES acts as CLR, reserved codes
    v(5'hC, 0, 16'h000C, 0, 0, 0); v(KEY_AND, 0, 16'h000C, 0, 1, 0);
    v(5'hA, 0, 16'h000A, 1, 1, 0); v(KEY_OR, 0, 16'h0008, 0, 1, 0);
    v(5'h3, 0, 16'h0003, 1, 1, 0); v(KEY_EXE, 0, 16'h000B, 2, 2, 0);
    v(KEY_CE, 0, 16'h0000, 0, 0, 0); v(5'h18, 0, 16'h0000, 0, 0, 0);
    v(5'h1F, 0, 16'h0000, 0, 0, 0);
    // MULT key and EXE in S_A
    v(5'h3, 0, 16'h0003, 0, 0, 0); v(KEY_EXE, 0, 16'h0003, 0, 0, 0);
    if (MULT_EN) begin
      v(KEY_MULT, 0, 16'h0003, 0, 1, 0); v(5'h4, 0, 16'h0004, 1, 1, 0);
      v(KEY_EXE, 0, 16'h000C, 2, 2, 0);
    end else begin
      v(KEY_MULT, 0, 16'h0003, 0, 0, 0); v(5'h4, 0, 16'h0034, 0, 0, 0);
      v(KEY_EXE, 0, 16'h0034, 0, 0, 0);
    end
    v(KEY_CLR, 1, 16'h0000, 0, 0, 0);
    // decimal entry
    v(5'h9, 1, 16'd9, 0, 0, 0); v(5'hA, 1, 16'd9, 0, 0, 0);
    v(5'h9, 1, 16'd99, 0, 0, 0);
    if (MULT_EN) begin
      v(KEY_MULT, 1, 16'd99, 0, 1, 0); v(5'h1, 1, 16'd1, 1, 1, 0);
      v(5'h1, 1, 16'd11, 1, 1, 0); v(KEY_EXE, 1, 16'd1089, 2, 2, 0);
    end else begin
      v(KEY_MULT, 1, 16'd99, 0, 0, 0); v(5'h1, 1, 16'd991, 0, 0, 0);
      v(5'h1, 1, 16'd9911, 0, 0, 0); v(KEY_EXE, 1, 16'd9911, 0, 0, 0);
    end
    v(KEY_CLR, 1, 16'h0000, 0, 0, 0);
    // radix change mid-entry keeps the stored value
    v(5'h1, 1, 16'd12 / 16'd12, 0, 0, 0); v(5'h2, 1, 16'd12, 0, 0, 0);
    v(5'hA, 0, 16'h00CA, 0, 0, 0); v(5'h5, 0, 16'h0CA5, 0, 0, 0);
    v(5'h6, 0, 16'h0CA5, 0, 0, 0); v(KEY_CLR, 0, 16'h0000, 0, 0, 0);
  end

  // ---------------- main sequence ----------------
  initial begin
    #1;
    do_reset();
    chk("reset_val",   32'(disp_val), 32'h0);
    chk("reset_sel",   32'(disp_sel), 32'h0);
    chk("reset_state", 32'(state),    32'h0);
    chk("reset_op",    32'(op_cur),   32'(OP_ADD));
    chk("reset_ovf",   32'(ovf),      32'h0);
    chk("reset_restr", 32'(restriction), 32'h0);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, vecs[i].key, vecs[i].dec);
      chk($sformatf("vec%0d_val", i),   32'(disp_val), 32'(vecs[i].val));
      chk($sformatf("vec%0d_sel", i),   32'(disp_sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_state", i), 32'(state),    32'(vecs[i].st));
      chk($sformatf("vec%0d_ovf", i),   32'(ovf),      32'(vecs[i].ovf));
      chk($sformatf("vec%0d_restr", i), 32'(restriction), 32'(vecs[i].dec));
    end

    // restriction latency: no key, dec_mode rises between edges
    dec_mode = 1'b1;
    #1;
    chk("restr_before_edge", 32'(restriction), 32'h0);
    @(posedge clk); #1;
    chk("restr_after_edge", 32'(restriction), 32'h1);
    dec_mode = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-entry in S_B with A=0x12, key_press held high
    do_reset();
    step(1'b1, 5'h1, 1'b0); step(1'b1, 5'h2, 1'b0); step(1'b1, KEY_ADD, 1'b0);
    step(1'b1, 5'h3, 1'b0);
    m_compare("pre_arst");
    #3;
    rst = 1'b1; key_press = 1'b1; key_val = 5'h5;
    #1;
    chk("arst_imm_val",   32'(disp_val), 32'h0);
    chk("arst_imm_state", 32'(state),    32'h0);
    chk("arst_imm_op",    32'(op_cur),   32'(OP_ADD));
    @(posedge clk); #1;
    chk("arst_hold_val",   32'(disp_val), 32'h0);
    chk("arst_hold_state", 32'(state),    32'h0);
    rst = 1'b0; key_press = 1'b0;
    m_reset();
    step(1'b1, 5'h7, 1'b0);
    m_compare("post_arst");

    // Random keys against the reference model
    begin
      bit d = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        int r;
        bit p;
        logic [4:0] k;
        p = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 99);
        if (r < 55)      k = 5'($urandom_range(0, 15));
        else if (r < 80) begin
          case ($urandom_range(0, 4))
            0: k = KEY_ADD; 1: k = KEY_MULT; 2: k = KEY_AND; 3: k = KEY_SUB;
            default: k = KEY_OR;
          endcase
        end
        else if (r < 88) k = KEY_EXE;
        else if (r < 94) k = KEY_CE;
        else if (r < 97) k = KEY_CLR;
        else             k = 5'($urandom_range(24, 31));
        if ($urandom_range(0, 19) == 0) d = ~d;
        step(p, k, d);
        m_compare("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_entry_fsm.md
# calc_entry_fsm

Keystroke interpreter for the grid calculator. It sits directly downstream of the grid cursor: each confirmed press delivers the 5-bit key code under the cursor. The block accumulates operand digits, latches the operator and runs the arithmetic on EXE, CE and CLR. It drives the value shown on the display and the decimal-mode restriction flag fed back to the cursor.

## Interface
Parameters:
- N_DIGITS, 4: maximum digits per operand. Operand width W = 4*N_DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- key_press  in  1  one-cycle pulse: the key is confirmed
- key_val  in  5  key code under the cursor, sampled only when key_press=1
- dec_mode  in  1  1 = decimal entry, 0 = hex entry
- restriction  out  1  equal to dec_mode, registered; goes to the cursor
- disp_val  out  W  value to display (binary)
- disp_sel  out  2  what is shown: 0 = A, 1 = B, 2 = result
- op_cur  out  3  latched operator, encoded per the package
- ovf  out  1  last computation overflowed W bits
- state  out  2  current FSM state, for debug and display

## Operation
- Key codes: 0x00–0x0F digit; 0x10 ADD; 0x11 MULT; 0x12 AND; 0x13 EXE; 0x14 SUB; 0x15 OR; 0x16 CE; 0x17 CLR.
- Codes 0x18–0x1F are ignored.
- Digit accumulation:
  - hex mode: acc = (acc<<4)|d.
  - decimal mode: acc = acc*10+d.
  - In decimal mode, digits above 9 are ignored.
  - Each operand has its own digit counter. Once the counter reaches N_DIGITS, further digits are ignored.
- FSM states: S_A=0, S_B=1, S_RES=2.
  - S_A: digits go into A. An operator key latches op and moves to S_B with B=0 and B-count=0. EXE is ignored.
  - S_B: digits go into B.
    - An operator key with B-count=0 only replaces op.
    - An operator key with B-count>0 chains: A <= A op B, ovf updated, new op latched, B cleared, stay in S_B.
    - EXE: R <= A op B (B=0 if no digits were entered), ovf updated, go to S_RES.
  - S_RES:
    - A digit clears everything, loads the digit into A and goes to S_A.
    - An operator key sets A <= R, latches op and goes to S_B.
    - EXE is ignored.
- CE: clears the operand currently being entered and its counter, with no state change. In S_RES it behaves as CLR.
- CLR: A, B, R, counters and ovf go to 0, op goes to ADD, state goes to S_A.
- Arithmetic, unsigned, truncated to W bits:
  - ADD: ovf = carry out.
  - SUB: ovf = borrow (A<B); the result is the wrapped two's complement.
  - MULT: ovf = upper W bits of the 2W-bit product nonzero.
  - AND, OR: ovf = 0.
- Display selection: disp_val/disp_sel follow state. S_A shows A, S_B shows B (A while B-count=0), S_RES shows R.
- Toggling dec_mode mid-entry does not alter stored values. It only affects subsequent digits.

## Timing
- Reset values: state S_A; A, B and R = 0; counters = 0; op_cur = ADD; ovf = 0; disp_val = 0; disp_sel = 0; restriction = 0.
- Asynchronous reset. It takes effect immediately, including mid-entry or mid-chain, and overrides key_press.
- Every key takes effect at the clk edge where key_press=1. Outputs reflect the key one cycle later; the computation is single-cycle.
- key_press high on consecutive cycles means consecutive keys. No buffering is needed; each cycle is handled independently.
- restriction follows dec_mode with 1-cycle latency.

## Configuration
- CALC_MULT_EN:
  - Defined: MULT (0x11) is supported as above.
  - Undefined: no multiplier is instantiated and 0x11 is treated as an ignored code in every state.

## Structure
- Package calc_pkg contains:
  - key-code localparams (KEY_ADD … KEY_CLR);
  - typedef enum op_t {OP_ADD, OP_SUB, OP_MULT, OP_AND, OP_OR};
  - typedef enum state_t {S_A, S_B, S_RES}.
- One sub-module, calc_alu. It is combinational, parameterised by W, takes A, B and op, and returns result and ovf.
- The MULT path inside calc_alu is guarded by CALC_MULT_EN.

## Test plan
- Hex, N_DIGITS=4: keys 1,2,ADD,3,4,EXE → disp_val=0x0046, disp_sel=2, ovf=0.
- Decimal: keys 9,9,MULT,1,1,EXE → R=1089 (0x0441). Key 0x0A is ignored in S_A, and restriction=1 one cycle after dec_mode=1.
- Overflow and digit limit: hex keys F,F,F,F,F (the fifth is ignored), then ADD,1,EXE → R=0x0000, ovf=1. Then SUB → A=0, S_B.
- Chaining and CE: hex keys 5,ADD,3,SUB (A=8), 7,CE,2,EXE → R=6. Then CLR → all zero, state S_A.
- Asynchronous reset asserted between clk edges in S_B with A=0x12 → outputs zero immediately. key_press held high during reset has no effect.
- With CALC_MULT_EN undefined: keys 3,MULT,4,EXE → MULT is ignored, the 4 is appended to A (0x34), and EXE in S_A is ignored.
